// File: rtl/common_pkg.sv
// common_pkg: fetch-bus and memory-bus types shared across the core.
//   ibus_req_t/ibus_resp_t : core fetch port
//   cbus_req_t/cbus_resp_t : burst-capable memory bus
package common_pkg;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] MSIZE8         = 3'b011;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

// File: rtl/icache_pkg.sv
// icache_pkg: cache FSM states and address-field width helpers.
package icache_pkg;
    typedef enum logic {IDLE, FETCH} icache_state_t;
    function automatic int word_bits(input int line_words);
        return $clog2(line_words);
    endfunction
    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction
    function automatic int tag_bits(input int sets, input int line_words);
        return 64 - 3 - $clog2(line_words) - $clog2(sets);
    endfunction
endpackage

// File: rtl/icache_data_array.sv
// icache_data_array: SETS x LINE_WORDS x 64-bit line storage.
//   clk            : clock
//   we/wset/wbeat  : refill write port, one 64-bit beat per cycle
//   wdata          : refill data
//   rset/rword     : combinational lookup read port
//   rdata          : selected 64-bit word
module icache_data_array
    import icache_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic [index_bits(SETS)-1:0]     wset,
    input  logic [word_bits(LINE_WORDS)-1:0] wbeat,
    input  logic [63:0]                     wdata,
    input  logic [index_bits(SETS)-1:0]     rset,
    input  logic [word_bits(LINE_WORDS)-1:0] rword,
    output logic [63:0]                     rdata
);
    logic [63:0] mem [SETS*LINE_WORDS];

    always_ff @(posedge clk)
        if (we) mem[{wset, wbeat}] <= wdata;

    assign rdata = mem[{rset, rword}];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with single-burst line refill.
//   clk, rst           : clock, synchronous active-high reset
//   ireq / iresp       : core fetch port; hits answered in the request cycle
//   creq / cresp       : memory bus; one INCR burst of LINE_WORDS beats per miss
//   flush              : invalidate all lines
//   hit_cnt / miss_cnt : saturating hit/miss counters
module icache
    import common_pkg::*;
    import icache_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  ibus_req_t   ireq,
    output ibus_resp_t  iresp,
    output cbus_req_t   creq,
    input  cbus_resp_t  cresp,
    input  logic        flush,
    output logic [63:0] hit_cnt,
    output logic [63:0] miss_cnt
);
    localparam int WB = word_bits(LINE_WORDS);
    localparam int IB = index_bits(SETS);
    localparam int TB = tag_bits(SETS, LINE_WORDS);
    localparam int LO = 3 + WB;

    icache_state_t state, state_d;
    logic [SETS-1:0] valid_q;
    logic [TB-1:0]   tag_arr [SETS];
    logic [63-LO:0]  line_q;
    logic [WB-1:0]   beat;
    logic            flush_pend;
    logic [IB-1:0]   idx, r_idx;
    logic [TB-1:0]   tag;
    logic [WB-1:0]   word;
    logic [63:0]     rdata;
    logic            hit, miss, fill, done;
    logic            unused;

    assign unused = ^ireq.addr[1:0];
    assign idx    = ireq.addr[LO +: IB];
    assign tag    = ireq.addr[63 -: TB];
    assign word   = ireq.addr[3 +: WB];
    assign r_idx  = line_q[IB-1:0];

    // A same-cycle flush forces the lookup to miss so no stale line is served.
    assign hit  = state == IDLE && ireq.valid && valid_q[idx] && tag_arr[idx] == tag && !flush;
    assign miss = state == IDLE && ireq.valid && !hit;
    assign fill = state == FETCH && cresp.ready;
    assign done = fill && cresp.last;

    always_comb begin
        state_d = miss ? FETCH : done ? IDLE : state;
        iresp   = '{addr_ok: hit, data_ok: hit,
                    data: hit ? (ireq.addr[2] ? rdata[63:32] : rdata[31:0]) : 32'h0};
        creq    = '{valid: state == FETCH, is_write: 1'b0, size: MSIZE8,
                    addr: {line_q, {LO{1'b0}}}, strobe: 8'h0, data: 64'h0,
                    len: 8'(LINE_WORDS - 1), burst: AXI_BURST_INCR};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid_q    <= '0;
            beat       <= '0;
            flush_pend <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            state <= state_d;
            if (miss) line_q <= ireq.addr[63:LO];
            // beat wraps to zero on the last beat since LINE_WORDS is a power of two
            if (fill) beat <= beat + 1'b1;
            if (flush) valid_q <= '0;
            // A flush seen at any point of the burst leaves the refilled line invalid.
            if (done) valid_q[r_idx] <= !flush && !flush_pend;
            flush_pend <= done ? 1'b0 : flush_pend | (flush && state == FETCH);
            if (hit && !(&hit_cnt)) hit_cnt <= hit_cnt + 64'd1;
            if (miss && !(&miss_cnt)) miss_cnt <= miss_cnt + 64'd1;
        end
    end

    always_ff @(posedge clk)
        if (done) tag_arr[r_idx] <= line_q[63-LO -: TB];

    always_ff @(posedge clk)
        if (!rst) begin
            assert (!(fill && cresp.last && beat != WB'(LINE_WORDS - 1)))
                else $error("icache: cbus last before final beat");
            assert (!(state == IDLE && cresp.ready))
                else $error("icache: cbus ready outside a burst");
        end

    icache_data_array #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) u_data (
        .clk   (clk),
        .we    (fill),
        .wset  (r_idx),
        .wbeat (beat),
        .wdata (cresp.data),
        .rset  (idx),
        .rword (word),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed scoreboard bench for icache with a burst memory responder.
module tb_icache;
    import common_pkg::*;

    localparam int SETS = 64;
    localparam int LW   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    cbus_req_t   creq;
    cbus_resp_t  cresp;
    logic [63:0] hit_cnt, miss_cnt;

    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          req_cyc = 0;
    int          mem_beat = 0;
    logic        stall_en = 1'b0;
    logic [31:0] gen = 32'h0;
    logic [31:0] sb[$];
    cbus_req_t   burst_req;

    icache #(.SETS(SETS), .LINE_WORDS(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ireq     (ireq),
        .iresp    (iresp),
        .creq     (creq),
        .cresp    (cresp),
        .flush    (flush),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [63:0] mem_word(input logic [63:0] a, input logic [31:0] g);
        return {a[31:0] ^ 32'hDEAD_BEEF ^ g, a[31:0] + 32'h0101_0101 + g};
    endfunction

    function automatic logic [31:0] exp_instr(input logic [63:0] a, input logic [31:0] g);
        logic [63:0] w;
        w = mem_word({a[63:3], 3'b000}, g);
        return a[2] ? w[63:32] : w[31:0];
    endfunction

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: answers bursts, optionally stalling, and watches creq stability.
    initial begin
        cresp = '0;
        forever begin
            @(posedge clk);
            if (rst) mem_beat = 0;
            else if (cresp.ready) mem_beat = cresp.last ? 0 : mem_beat + 1;
            #1;
            if (creq.valid) begin
                if (mem_beat == 0) burst_req = creq;
                else check("creq_stable", 160'(creq), 160'(burst_req));
                cresp.ready = !(stall_en && $urandom_range(3) == 0);
                cresp.last  = cresp.ready && mem_beat == LW - 1;
                cresp.data  = mem_word(creq.addr + 64'(mem_beat * 8), gen);
            end else begin
                cresp = '0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic issue(input logic [63:0] a);
        ireq.valid = 1'b1;
        ireq.addr  = a;
        req_cyc    = cyc;
    endtask

    task automatic wait_resp(input string tag, input int lat);
        int n;
        logic [31:0] e;
        n = 0;
        while (!iresp.data_ok && n <= 200) begin
            @(negedge clk);
            if (!iresp.data_ok) n++;
        end
        e = sb.pop_front();
        if (!iresp.data_ok) check({tag, "_timeout"}, 160'(0), 160'(1));
        else begin
            check(tag, 160'(iresp.data), 160'(e));
            if (lat >= 0) check({tag, "_latency"}, 160'(cyc - req_cyc), 160'(lat));
        end
        @(posedge clk);
        #1;
        ireq.valid = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] a, input int lat, input string tag);
        sb.push_back(exp_instr(a, gen));
        issue(a);
        @(negedge clk);
        wait_resp(tag, lat);
    endtask

    task automatic check_cnt(input string tag, input int hits, input int misses);
        check({tag, "_hit_cnt"}, 160'(hit_cnt), 160'(hits));
        check({tag, "_miss_cnt"}, 160'(miss_cnt), 160'(misses));
    endtask

    initial begin
        ireq = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_iresp", 160'(iresp), 160'(0));
        check("reset_creq_valid", 160'(creq.valid), 160'(0));
        check_cnt("reset", 0, 0);
        @(posedge clk);
        #1;

        // cold miss with bus-field checks during the burst
        sb.push_back(exp_instr(64'h8000_0000, gen));
        issue(64'h8000_0000);
        @(negedge clk);
        check("cold_req_dataok", 160'(iresp.data_ok), 160'(0));
        @(negedge clk);
        check("cold_creq_valid", 160'(creq.valid), 160'(1));
        check("cold_creq_len", 160'(creq.len), 160'(3));
        check("cold_creq_addr", 160'(creq.addr), 160'(64'h8000_0000));
        check("cold_creq_size", 160'(creq.size), 160'(MSIZE8));
        check("cold_creq_burst", 160'(creq.burst), 160'(AXI_BURST_INCR));
        check("cold_creq_write", 160'(creq.is_write), 160'(0));
        wait_resp("cold", 5);
        check_cnt("cold", 1, 1);

        for (int i = 1; i < 8; i++) fetch(64'h8000_0000 + 64'(4 * i), 0, "seq");
        check_cnt("seq", 8, 1);

        fetch(64'h8000_0000 + 64'(SETS * LW * 8), 5, "conflict_b");
        fetch(64'h8000_0000, 5, "conflict_a");
        check_cnt("conflict", 10, 3);

        // flush in the lookup cycle forces a miss on a resident line
        sb.push_back(exp_instr(64'h8000_0008, gen));
        issue(64'h8000_0008);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        wait_resp("idle_flush", 5);
        check_cnt("idle_flush", 11, 4);

        // flush at beat 2: burst drains, line stays invalid, a second burst follows
        issue(64'h8000_1010);
        repeat (3) @(posedge clk);
        #1;
        gen   = 32'h5A5A_0001;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        sb.push_back(exp_instr(64'h8000_1010, gen));
        wait_resp("flush_mid", 10);
        check_cnt("flush_mid", 12, 6);

        stall_en = 1'b1;
        for (int i = 0; i < 32; i++) fetch(64'h8000_2000 + 64'(12 * i), -1, "stall");
        stall_en = 1'b0;
        check_cnt("stall", 44, 18);

        // reset while beat 1 of a refill is on the bus
        issue(64'h8000_3000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        ireq.valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_creq_valid", 160'(creq.valid), 160'(0));
        check("rst_mid_iresp", 160'(iresp), 160'(0));
        check_cnt("rst_mid", 0, 0);
        @(posedge clk);
        #1;
        fetch(64'h8000_3000, 5, "post_rst");
        fetch(64'h8000_0000, 5, "post_rst_old");
        check_cnt("post_rst", 2, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
